fir_filter_folded: RTL and testbench

- Parametrised successor to the 32-tap parallel FIR front end of FAS.
- Single folded MAC, time-multiplexed over N_TAPS taps. Coefficients are runtime-programmable through a write port instead of a compile-time include.
- Adds ready/valid handshakes, rounding, an explicit stream clear and a warm-up gate.
- Feeds the serial-to-parallel / FFT stage.

---
 rtl/fir_filter_folded_if.sv | 34 +++
 rtl/fir_filter_folded.sv | 136 +++++++++++++
 tb/tb_fir_filter_folded.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_filter_folded_if.sv
// Sample/coefficient/output handshake bundle for fir_filter_folded; the DUT uses the slave view.
// FIR_SAT_EN adds the sat_flag output.
interface fir_filter_folded_if #(
  parameter int N_TAPS = 32,
  parameter int DATA_W = 16,
  parameter int COEF_W = 20,
  parameter int OUT_W  = 16
);
  localparam int AW = $clog2(N_TAPS);

  logic                     clear;
  logic                     data_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] data;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     fir_valid;
  logic                     fir_ready;
  logic signed [OUT_W-1:0]  fir_d;
`ifdef FIR_SAT_EN
  logic                     sat_flag;

  modport master (output clear, data_valid, data, coef_we, coef_addr, coef_wdata, fir_ready,
                  input in_ready, fir_valid, fir_d, sat_flag);
  modport slave  (input clear, data_valid, data, coef_we, coef_addr, coef_wdata, fir_ready,
                  output in_ready, fir_valid, fir_d, sat_flag);
`else
  modport master (output clear, data_valid, data, coef_we, coef_addr, coef_wdata, fir_ready,
                  input in_ready, fir_valid, fir_d);
  modport slave  (input clear, data_valid, data, coef_we, coef_addr, coef_wdata, fir_ready,
                  output in_ready, fir_valid, fir_d);
`endif
endinterface

// File: rtl/fir_filter_folded.sv
// Folded single-MAC FIR, one tap per cycle: output N_TAPS cycles after acceptance, one sample per N_TAPS+2 cycles.
// in_ready only in IDLE; OUT holds fir_d until fir_ready. FIR_SAT_EN selects clamping plus sat_flag.
module fir_filter_folded #(
  parameter int N_TAPS     = 32,
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 20,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 16
) (
  input  logic               clk,
  input  logic               rst,
  fir_filter_folded_if.slave bus
);
  localparam int AW    = $clog2(N_TAPS);
  localparam int FW    = $clog2(N_TAPS + 1);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + AW;
  localparam int RW    = ACC_W + 1;
  localparam logic signed [RW-1:0] HALF = RW'(1) <<< (FRAC_SHIFT - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state, state_nxt;
  logic signed [DATA_W-1:0] hist [N_TAPS];
  logic signed [COEF_W-1:0] coef [N_TAPS];
  logic [AW-1:0]            wr_ptr, base, tap, rd_idx;
  logic [FW-1:0]            fill;
  logic signed [ACC_W-1:0]  acc, acc_sum;
  logic signed [PW-1:0]     hist_rd, coef_rd, prod;
  logic signed [RW-1:0]     biased, r_full;
  logic signed [OUT_W-1:0]  fir_d_q, out_nxt;
  logic                     accept, coef_wr, last_tap, warm;

  assign accept   = (state == IDLE) && bus.data_valid && !bus.clear;
  assign coef_wr  = (state == IDLE) && bus.coef_we && !bus.clear && (int'(bus.coef_addr) < N_TAPS);
  assign last_tap = (tap == AW'(N_TAPS - 1));
  assign warm     = (fill >= FW'(N_TAPS));

  // Newest sample sits at base; tap k reads x[n-k] walking backwards around the ring.
  assign rd_idx  = (tap > base) ? (base + AW'(N_TAPS) - tap) : (base - tap);
  assign hist_rd = PW'(hist[rd_idx]);
  assign coef_rd = PW'(coef[tap]);
  assign prod    = hist_rd * coef_rd;
  assign acc_sum = acc + {{AW{prod[PW-1]}}, prod};

`ifdef FIR_SAT_EN
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic sat_nxt, sat_q;

  always_comb begin
    biased  = {acc_sum[ACC_W-1], acc_sum} + HALF;
    r_full  = biased >>> FRAC_SHIFT;
    out_nxt = r_full[OUT_W-1:0];
    sat_nxt = 1'b0;
    if (r_full > SAT_MAX) begin
      out_nxt = SAT_MAX[OUT_W-1:0];
      sat_nxt = 1'b1;
    end else if (r_full < SAT_MIN) begin
      out_nxt = SAT_MIN[OUT_W-1:0];
      sat_nxt = 1'b1;
    end
  end

  assign bus.sat_flag = sat_q && (state == OUT);
`else
  logic unused_r_hi;

  always_comb begin
    biased  = {acc_sum[ACC_W-1], acc_sum} + HALF;
    r_full  = biased >>> FRAC_SHIFT;
    out_nxt = r_full[OUT_W-1:0];
  end

  assign unused_r_hi = &{1'b0, r_full[RW-1:OUT_W]};
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.data_valid) state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = warm ? OUT : IDLE;
      OUT:     if (bus.fir_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.clear) state_nxt = IDLE;
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.fir_valid = (state == OUT);
  assign bus.fir_d     = fir_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      base    <= '0;
      tap     <= '0;
      fill    <= '0;
      acc     <= '0;
      fir_d_q <= '0;
`ifdef FIR_SAT_EN
      sat_q   <= 1'b0;
`endif
      for (int i = 0; i < N_TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      // Coefficient lands on the same edge as a sample, so that sample's MAC sees it.
      if (coef_wr) coef[bus.coef_addr] <= bus.coef_wdata;
      if (bus.clear) begin
        wr_ptr <= '0;
        fill   <= '0;
        for (int i = 0; i < N_TAPS; i++) hist[i] <= '0;
      end else if (accept) begin
        hist[wr_ptr] <= bus.data;
        base         <= wr_ptr;
        wr_ptr       <= (wr_ptr == AW'(N_TAPS - 1)) ? '0 : wr_ptr + 1'b1;
        if (!warm) fill <= fill + 1'b1;
        acc <= '0;
        tap <= '0;
      end else if (state == MAC) begin
        acc <= acc_sum;
        if (!last_tap) tap <= tap + 1'b1;
        if (last_tap && warm) begin
          fir_d_q <= out_nxt;
`ifdef FIR_SAT_EN
          sat_q   <= sat_nxt;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_fir_filter_folded.sv
// Randomized bench for fir_filter_folded (N_TAPS=4) against a queue-based convolution model.
// Honours FIR_SAT_EN for the expected output rule and the sat_flag check.
module tb_fir_filter_folded;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int CW = 20;
  localparam int OW = 16;
  localparam int FS = 16;
  localparam int AW = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fir_filter_folded_if #(.N_TAPS(N), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW)) bus ();

  fir_filter_folded #(.N_TAPS(N), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .FRAC_SHIFT(FS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: newest sample at the front of m_hist, absent samples count as zero.
  longint m_coef [N];
  longint m_hist [$];
  int     m_fill;

  function automatic void m_push(input longint x);
    m_hist.push_front(x);
    if (m_hist.size() > N) void'(m_hist.pop_back());
    if (m_fill < N) m_fill++;
  endfunction

  function automatic void m_clear();
    m_hist.delete();
    m_fill = 0;
  endfunction

  function automatic longint m_expect(output bit sat);
    longint y, r, hi, lo;
    y = 0;
    for (int k = 0; k < N; k++)
      if (k < m_hist.size()) y += m_coef[k] * m_hist[k];
    r   = (y + (longint'(1) <<< (FS - 1))) >>> FS;
    hi  = (longint'(1) <<< (OW - 1)) - 1;
    lo  = -(hi + 1);
    sat = 1'b0;
`ifdef FIR_SAT_EN
    if (r > hi) begin r = hi; sat = 1'b1; end
    else if (r < lo) begin r = lo; sat = 1'b1; end
    return r;
`else
    r = r & ((longint'(1) <<< OW) - 1);
    if (r > hi) r -= (longint'(1) <<< OW);
    return r;
`endif
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && !bus.in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!bus.in_ready) check("idle_timeout", longint'(bus.in_ready), 1);
  endtask

  task automatic write_coef(input int a, input longint v);
    logic signed [CW-1:0] cv;
    cv = CW'(v);
    wait_idle();
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AW'(a);
    bus.coef_wdata = cv;
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
    m_coef[a]   = longint'(cv);
  endtask

  // mode 0: plain sample; 1: coef write in the accepting cycle; 2: same write issued during MAC (dropped).
  task automatic send(input longint x, input bit bp, input int mode, input int wa, input longint wv);
    logic signed [CW-1:0] cv;
    longint exp;
    bit     esat, want;
    int     lat;
    cv = CW'(wv);
    wait_idle();
    bus.data       = DW'(x);
    bus.data_valid = 1'b1;
    if (mode == 1) begin
      bus.coef_we    = 1'b1;
      bus.coef_addr  = AW'(wa);
      bus.coef_wdata = cv;
      m_coef[wa]     = longint'(cv);
    end
    if (bp) bus.fir_ready = 1'b0;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    bus.coef_we    = 1'b0;
    m_push(x);
    want = (m_fill >= N);
    exp  = m_expect(esat);
    lat  = 0;
    for (int n = 1; n <= N + 6; n++) begin
      if (mode == 2 && n == 1) begin
        bus.coef_we    = 1'b1;
        bus.coef_addr  = AW'(wa);
        bus.coef_wdata = cv;
      end
      @(posedge clk); #1;
      bus.coef_we = 1'b0;
      lat = n;
      if (bus.fir_valid || bus.in_ready) break;
    end
    check("latency", longint'(lat), longint'(N));
    check("fir_valid", longint'(bus.fir_valid), longint'(want));
    if (want) begin
      check("fir_d", longint'(bus.fir_d), exp);
`ifdef FIR_SAT_EN
      check("sat_flag", longint'(bus.sat_flag), longint'(esat));
`endif
      if (bp) begin
        for (int i = 0; i < 5; i++) begin
          if (i == 2) begin
            bus.data       = DW'(16'sd1234);
            bus.data_valid = 1'b1;
          end
          @(posedge clk); #1;
          bus.data_valid = 1'b0;
          check("bp_valid", longint'(bus.fir_valid), 1);
          check("bp_hold", longint'(bus.fir_d), exp);
          check("bp_in_ready", longint'(bus.in_ready), 0);
        end
        bus.fir_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", longint'(bus.fir_valid), 0);
      end
    end else begin
      check("warm_in_ready", longint'(bus.in_ready), 1);
    end
    bus.fir_ready = 1'b1;
  endtask

  task automatic send_clear(input longint x);
    bit seen;
    seen = 1'b0;
    wait_idle();
    bus.data       = DW'(x);
    bus.data_valid = 1'b1;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    m_clear();
    check("clear_idle", longint'(bus.in_ready), 1);
    for (int i = 0; i < N + 3; i++) begin
      @(posedge clk); #1;
      if (bus.fir_valid) seen = 1'b1;
    end
    check("clear_no_valid", longint'(seen), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [DW-1:0] rx;
    logic signed [CW-1:0] rc;
    int md;
    bit bpv;

    rst            = 1'b1;
    bus.clear      = 1'b0;
    bus.data_valid = 1'b0;
    bus.data       = '0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    bus.fir_ready  = 1'b1;
    for (int k = 0; k < N; k++) m_coef[k] = 0;
    m_clear();

    @(posedge clk); #1;
    check("rst_in_ready", longint'(bus.in_ready), 0);
    check("rst_fir_valid", longint'(bus.fir_valid), 0);
    check("rst_fir_d", longint'(bus.fir_d), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", longint'(bus.in_ready), 1);

    // Impulse through the 1/2/3/4 coefficient set.
    for (int k = 0; k < N; k++) write_coef(k, longint'(k + 1) * 65536);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    send(1, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);

    send(5, 1, 0, 0, 0);
    send(-3, 0, 0, 0, 0);

    // Rounding half toward +inf with c[0] = 0.5.
    write_coef(0, 32768);
    for (int k = 1; k < N; k++) write_coef(k, 0);
    send(1, 0, 0, 0, 0);
    send(-1, 0, 0, 0, 0);
    send(3, 0, 0, 0, 0);

    send(7, 0, 2, 0, 0);
    send(7, 0, 1, 0, 0);

    for (int k = 0; k < N; k++) write_coef(k, longint'(k + 1) * 65536);
    send_clear(9);
    send(2, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);

    for (int k = 0; k < N; k++) write_coef(k, 20'h7FFFF);
    for (int i = 0; i < N; i++) send(32767, 0, 0, 0, 0);

    for (int it = 0; it < 40; it++) begin
      rx  = DW'($urandom);
      rc  = CW'($urandom);
      md  = $urandom_range(0, 2);
      bpv = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) write_coef($urandom_range(0, N - 1), longint'(rc));
      send(longint'(rx), bpv, md, $urandom_range(0, N - 1), longint'(rc));
    end

    // Reset in the middle of a MAC wipes coefficients and history.
    wait_idle();
    bus.data       = DW'(16'sd11);
    bus.data_valid = 1'b1;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", longint'(bus.in_ready), 0);
    @(posedge clk); #1;
    check("midrst_fir_valid", longint'(bus.fir_valid), 0);
    check("midrst_fir_d", longint'(bus.fir_d), 0);
    rst = 1'b0;
    for (int k = 0; k < N; k++) m_coef[k] = 0;
    m_clear();
    for (int i = 0; i < N; i++) send(longint'(i + 100), 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
